// File: rtl/bit_count_unit.sv
// Bit-statistics engine: counts ones (mode=0) or zeros (mode=1) in a WIDTH-bit operand
// using a check/shift/test controller over operand R1, count R2 and shifted-out flag E.
module bit_count_unit #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    output logic             rdy,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StShift = 2'd2,
        StTest  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [CW-1:0]    r2_q, r2_d;
    logic             e_q, e_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        e_d     = e_q;
        done_d  = 1'b0;

        // Abort only matters mid-operation; R2 keeps its partial value.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        r1_d    = mode ? ~data_in : data_in;
                        r2_d    = '0;
                        e_d     = 1'b0;
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (r1_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StShift;
                    end
                end
                StShift: begin
                    e_d     = r1_q[WIDTH-1];
                    r1_d    = {r1_q[WIDTH-2:0], 1'b0};
                    state_d = StTest;
                end
                StTest: begin
                    if (e_q) begin
                        r2_d    = r2_q + CW'(1);
                        state_d = StCheck;
                    end else begin
                        state_d = StShift;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            r1_q    <= '0;
            r2_q    <= '0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            e_q     <= e_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        rdy   = (state_q == StIdle);
        busy  = ~rdy;
        done  = done_q;
        count = r2_q;
    end

endmodule

// File: doc/bit_count_unit.md
Name: bit_count_unit

Overview:
- Parametrised successor to the team's 8-bit ones-counter controller.
- Integrates the controller FSM (idle / check / shift / test states) with its datapath: operand register R1, count register R2 and shifted-out flag E.
- Counts ones or zeros in a WIDTH-bit operand and returns the count with a start/rdy/done handshake and an abort.
- Sits beside the shift-register datapath blocks as a self-contained bit-statistics engine.

Parameters:
- WIDTH, 8, operand width in bits; legal values are 2 or more.
- CW, $clog2(WIDTH+1), count width. It is derived from WIDTH and must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin; sampled only in S_IDLE.
- mode  input  1  0 = count ones, 1 = count zeros; captured with start.
- abort  input  1  cancels an operation in progress.
- data_in  input  WIDTH  operand; captured with start.
- rdy  output  1  high in S_IDLE (decoded from state).
- busy  output  1  equal to ~rdy.
- done  output  1  registered one-cycle pulse when a count completes.
- count  output  CW  result (R2); holds its value until the next accepted start.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to S_IDLE; R1=0, R2/count=0, E=0, done=0.
  - After the edge, rdy=1 and busy=0.
  - Reset has priority over every other input, including during an active operation.
- Priority order: rst, then abort, then normal transitions.
- S_IDLE:
  - start=1 loads R1 with data_in when mode=0, or ~data_in when mode=1.
  - The same edge clears R2 and E, and the next state is S_1.
  - Otherwise the block stays in S_IDLE and count holds its value.
- S_1 (check):
  - R1==0: next state S_IDLE and done=1 for exactly the following cycle.
  - R1!=0: next state S_2.
- S_2 (shift):
  - E <= R1[WIDTH-1] and R1 <= R1<<1 with zero fill.
  - Next state S_3.
- S_3 (test):
  - E=1: R2 <= R2+1, next state S_1.
  - E=0: next state S_2.
- Width rule: R2 never exceeds WIDTH, so CW bits are always enough and no overflow is possible.
- Latency (start-accepting edge = cycle 0; done high during cycle L):
  - L = 2 when the effective operand is zero.
  - Otherwise L = 2 + 2*(WIDTH - tz) + pop, where tz = trailing zeros and pop = popcount of the effective operand.
- abort=1 in any non-idle state:
  - Next state S_IDLE; done is not asserted.
  - count keeps the partial value. It is not a valid result.
- abort in S_IDLE has no effect.
- start while busy is ignored, and so is any change on mode or data_in.
- Back-to-back operation:
  - start during the done cycle (state is S_IDLE) is accepted.
  - count clears on the following edge.
- done never asserts while in reset, or during the cycle immediately after reset.

Test Plan:
1. Reset and idle, WIDTH=8:
   - Hold rst for 2 cycles, then release with start=0 for 5 cycles.
   - Required: rdy=1, busy=0, count=0, done=0 throughout.
2. Zero and zero-fill cases:
   - start with data_in=8'h00, mode=0 → done at cycle 2, count=0.
   - start with data_in=8'hFF, mode=1 → done at cycle 2, count=0.
3. Ones counting:
   - data_in=8'h80, mode=0 → done at cycle 5, count=1.
   - data_in=8'h01, mode=0 → done at cycle 19, count=1.
   - data_in=8'hFF, mode=0 → done at cycle 26, count=8.
   - data_in=8'hA5, mode=0 → count=4, done at cycle 2+16+4=22.
4. Zero counting and back-to-back:
   - data_in=8'hF0, mode=1 → count=4.
   - Re-assert start in the done cycle with data_in=8'h03, mode=0 → accepted immediately, next count=2.
   - start pulses while busy are ignored.
5. Abort and reset mid-operation:
   - data_in=8'hFF, abort at cycle 6 → rdy=1 next cycle, no done pulse.
   - Repeat with rst at cycle 6 → count=0 after the edge, no done pulse.
6. WIDTH=16 instance (CW=5):
   - data_in=16'hFFFF, mode=0 → count=16, done at cycle 50.
   - data_in=16'h0000, mode=1 → count=16.
